// File: rtl/corescore_rst_pkg.sv
// Shared definitions for the CoreScore reset sequencer: state encoding and
// counter sizing.
package corescore_rst_pkg;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        HOLD = 2'd1,
        REL  = 2'd2,
        RUN  = 2'd3
    } state_t;

    // One counter width serves the hold, stagger and loss counters.
    // The extra bit keeps the largest terminal count from wrapping.
    function automatic int cnt_width(input int lock_wait, input int stagger,
                                     input int loss_filter);
        int m;
        m = lock_wait;
        if (stagger > m)     m = stagger;
        if (loss_filter > m) m = loss_filter;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/corescore_sync_ff.sv
// N-stage single-bit synchroniser with asynchronous active-low clear.
// Used for LOCKED here and reusable for other single-bit CDC crossings.
module corescore_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/corescore_rst_seq.sv
// Reset sequencer: waits for a stable PLL/MMCM lock, then releases NUM_RST
// active-high resets one at a time, re-sequencing on lock loss or on a
// software request.
//
// state | meaning
// ------+-----------------------------------------------------------------
// WAIT  | all resets asserted, waiting for synchronised LOCKED
// HOLD  | lock seen, counting LOCK_WAIT cycles before releasing o_rst[0]
// REL   | releasing o_rst[1..NUM_RST-1], one every STAGGER cycles
// RUN   | all resets released, o_ready high
module corescore_rst_seq
    import corescore_rst_pkg::*;
#(
    parameter int NUM_RST     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_WAIT   = 4,
    parameter int STAGGER     = 2,
    parameter int LOSS_FILTER = 3
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_locked,
    input  logic               i_sw_rst,
    output logic [NUM_RST-1:0] o_rst,
    output logic               o_ready
);

    localparam int CW = cnt_width(LOCK_WAIT, STAGGER, LOSS_FILTER);

    localparam logic [CW-1:0] HOLD_TC = CW'(LOCK_WAIT - 1);
    localparam logic [CW-1:0] STAG_TC = CW'(STAGGER - 1);
    localparam logic [CW-1:0] LOSS_TC = CW'(LOSS_FILTER - 1);

    if (NUM_RST < 1 || SYNC_STAGES < 2 || LOCK_WAIT < 1 ||
        STAGGER < 1 || LOSS_FILTER < 1) begin : g_bad_param
        $error("corescore_rst_seq: illegal parameter value");
    end

    logic               w_locked_s;
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt, w_cnt_nxt;
    logic [CW-1:0]      r_loss, w_loss_nxt;
    logic [NUM_RST-1:0] r_rst, w_rst_nxt;
    logic               r_ready, w_ready_nxt;
    logic [NUM_RST-1:0] w_rst_shift;

    corescore_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_locked),
        .o_q     (w_locked_s)
    );

    // Bit 0 releases first; shifting left clears the next higher bit.
    assign w_rst_shift = r_rst << 1;

    // State, counters and output flops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= WAIT;
            r_cnt   <= '0;
            r_loss  <= '0;
            r_rst   <= '1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_loss  <= w_loss_nxt;
            r_rst   <= w_rst_nxt;
            r_ready <= w_ready_nxt;
        end
    end

    // Next-state and next-output logic; lock loss overrides software request.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_nxt  = r_loss;
        w_rst_nxt   = r_rst;
        w_ready_nxt = r_ready;

        if (r_state == WAIT) begin
            w_cnt_nxt  = '0;
            w_loss_nxt = '0;
            if (w_locked_s) begin
                w_state_nxt = HOLD;
            end
        end else begin
            w_loss_nxt = w_locked_s ? '0 : r_loss + CW'(1);

            case (r_state)
                HOLD: begin
                    if (r_cnt == HOLD_TC) begin
                        w_cnt_nxt   = '0;
                        w_rst_nxt   = w_rst_shift;
                        w_ready_nxt = (w_rst_shift == '0);
                        w_state_nxt = (w_rst_shift == '0) ? RUN : REL;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                REL: begin
                    if (r_cnt == STAG_TC) begin
                        w_cnt_nxt   = '0;
                        w_rst_nxt   = w_rst_shift;
                        w_ready_nxt = (w_rst_shift == '0);
                        w_state_nxt = (w_rst_shift == '0) ? RUN : REL;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase

            if (i_sw_rst) begin
                w_state_nxt = HOLD;
                w_cnt_nxt   = '0;
                w_rst_nxt   = '1;
                w_ready_nxt = 1'b0;
            end

            if (!w_locked_s && r_loss == LOSS_TC) begin
                w_state_nxt = WAIT;
                w_cnt_nxt   = '0;
                w_loss_nxt  = '0;
                w_rst_nxt   = '1;
                w_ready_nxt = 1'b0;
            end
        end
    end

    assign o_rst   = r_rst;
    assign o_ready = r_ready;

endmodule
